// File: rtl/serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial WIDTH-bit adder controller. One 1-bit full-adder cell (two
// half_adder instances plus an OR for the carry) is time-shared across all
// bit positions. Operands are captured on an accepted START and run through
// the cell LSB-first, one bit per clock. The result, carry-out and a
// one-cycle DONE pulse are returned at the end of the operation.
//
// Optional feature macro: SERIAL_ADD_SUB_EN
//   When defined, adds input SUB. SUB=1 computes A-B as A+~B+1 (B inverted at
//   capture, carry flop preset to 1); CARRY=1 then means no borrow.
//   When undefined, the block is addition only.
//
// Parameters:
//   WIDTH   operand/result width in bits (legal range 2..32)
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   START   operation request, sampled only in IDLE
//   A, B    operands, captured on an accepted START
//   SUB     (SERIAL_ADD_SUB_EN only) subtract select, captured with A/B
//   SUM     last completed result
//   CARRY   carry-out of the last completed operation
//   BUSY    high while an operation is in RUN or DONE
//   DONE    one-cycle pulse; SUM/CARRY newly updated
// ----------------------------------------------------------------------------

// Half adder: s = a ^ b, c = a & b.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             SUB,
`endif
    output logic [WIDTH-1:0] SUM,
    output logic             CARRY,
    output logic             BUSY,
    output logic             DONE
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Datapath registers
    logic [WIDTH-1:0] opa_sr;
    logic [WIDTH-1:0] opb_sr;
    logic [WIDTH-1:0] res_sr;
    logic             cy_q;
    logic [CW-1:0]    cnt;

    // Control strobes from the FSM
    logic load;
    logic shift;
    logic last;

    // Subtract select (constant 0 in the addition-only build)
    logic sub_in;
`ifdef SERIAL_ADD_SUB_EN
    assign sub_in = SUB;
`else
    assign sub_in = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Full-adder cell: two half adders, carry = c0 | c1
    // ------------------------------------------------------------------
    logic ha0_s, ha0_c;
    logic sum_bit, ha1_c;
    logic cell_cout;

    half_adder u_ha0 (
        .a (opa_sr[0]),
        .b (opb_sr[0]),
        .s (ha0_s),
        .c (ha0_c)
    );

    half_adder u_ha1 (
        .a (ha0_s),
        .b (cy_q),
        .s (sum_bit),
        .c (ha1_c)
    );

    assign cell_cout = ha0_c | ha1_c;

    // Result shift register value after the current RUN edge
    logic [WIDTH-1:0] res_next;
    assign res_next = {sum_bit, res_sr[WIDTH-1:1]};

    // Last bit is being processed when WIDTH-1 bits are already done
    assign last = (cnt == CW'(WIDTH - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        BUSY    = 1'b0;
        DONE    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    load    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                BUSY  = 1'b1;
                shift = 1'b1;
                if (last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                BUSY    = 1'b1;
                DONE    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_sr <= '0;
            opb_sr <= '0;
            res_sr <= '0;
            cy_q   <= 1'b0;
            cnt    <= '0;
            SUM    <= '0;
            CARRY  <= 1'b0;
        end else if (load) begin
            opa_sr <= A;
            opb_sr <= B ^ {WIDTH{sub_in}};
            res_sr <= '0;
            cy_q   <= sub_in;
            cnt    <= '0;
        end else if (shift) begin
            opa_sr <= opa_sr >> 1;
            opb_sr <= opb_sr >> 1;
            res_sr <= res_next;
            cy_q   <= cell_cout;
            cnt    <= cnt + CW'(1);
            // The DONE entry edge is also the edge that produces the MSB,
            // so the outputs take the post-shift value directly.
            if (last) begin
                SUM   <= res_next;
                CARRY <= cell_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Directed self-checking bench for serial_add_ctrl with WIDTH=8. Each check
// is an immediate assertion against a hand-computed expected value.
// Cycle numbering: the START edge is edge 0; DONE visible after edge 8 means
// DONE is high in the 9th cycle counted from the start edge.
// ----------------------------------------------------------------------------
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       START;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] SUM;
    logic       CARRY;
    logic       BUSY;
    logic       DONE;
`ifdef SERIAL_ADD_SUB_EN
    logic       SUB;
`endif

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .START (START),
        .A     (A),
        .B     (B),
`ifdef SERIAL_ADD_SUB_EN
        .SUB   (SUB),
`endif
        .SUM   (SUM),
        .CARRY (CARRY),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Results gathered by run_op
    int         done_edge;
    int         busy_cycles;
    int         done_pulses;
    int         sum_moved;
    int         finished;
    logic [7:0] sum_at_done;
    logic       carry_at_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start one operation and follow it until BUSY drops (bounded to 30 edges).
    // held: value SUM must show while the run is in progress.
    // mid_k/ma/mb: optional extra START pulse before edge mid_k (-1 = none).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] held, input int mid_k,
                          input logic [7:0] ma, input logic [7:0] mb);
        @(negedge clk);
        A = a; B = b; START = 1'b1;
        @(posedge clk);
        #1;
        START = 1'b0;
        A = ~a; B = ~b;
        busy_cycles   = BUSY ? 1 : 0;
        done_edge     = -1;
        done_pulses   = 0;
        sum_moved     = 0;
        finished      = 0;
        sum_at_done   = 8'h00;
        carry_at_done = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == mid_k) begin
                A = ma; B = mb; START = 1'b1;
            end
            @(posedge clk);
            #1;
            START = 1'b0;
            if (BUSY) busy_cycles++;
            if (DONE) begin
                done_pulses++;
                if (done_edge < 0) begin
                    done_edge     = k;
                    sum_at_done   = SUM;
                    carry_at_done = CARRY;
                end
            end else if (BUSY && (SUM !== held || CARRY !== 1'b0 && held == 8'h46)) begin
                sum_moved++;
            end
            if (!BUSY) begin
                finished = 1;
                break;
            end
        end
    endtask

    initial begin
        int dn;
        int np;
        int bad;
        int d[3];

        rst_n = 1'b0;
        START = 1'b0;
        A     = 8'h00;
        B     = 8'h00;
`ifdef SERIAL_ADD_SUB_EN
        SUB   = 1'b0;
`endif
        #2;
        chk("reset_sum",   SUM,   8'h00);
        chk("reset_carry", CARRY, 1'b0);
        chk("reset_busy",  BUSY,  1'b0);
        chk("reset_done",  DONE,  1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: 0x5A + 0x3C = 0x096
        run_op(8'h5A, 8'h3C, 8'h00, -1, 8'h00, 8'h00);
        chk("t1_finished",  finished,      1);
        chk("t1_done_edge", done_edge,     8);
        chk("t1_busy_cyc",  busy_cycles,   9);
        chk("t1_pulses",    done_pulses,   1);
        chk("t1_sum",       sum_at_done,   8'h96);
        chk("t1_carry",     carry_at_done, 1'b0);
        chk("t1_sum_held",  sum_moved,     0);
        chk("t1_sum_after", SUM,           8'h96);

        // 2a: 0xFF + 0x01 = 0x100
        run_op(8'hFF, 8'h01, 8'h96, -1, 8'h00, 8'h00);
        chk("t2a_finished", finished,      1);
        chk("t2a_sum",      sum_at_done,   8'h00);
        chk("t2a_carry",    carry_at_done, 1'b1);
        chk("t2a_sum_held", sum_moved,     0);

        // 2b: 0xFF + 0xFF = 0x1FE; SUM holds 0x00 until its DONE
        run_op(8'hFF, 8'hFF, 8'h00, -1, 8'h00, 8'h00);
        chk("t2b_finished", finished,      1);
        chk("t2b_sum",      sum_at_done,   8'hFE);
        chk("t2b_carry",    carry_at_done, 1'b1);
        chk("t2b_sum_held", sum_moved,     0);
        chk("t2b_done_edge", done_edge,    8);

        // 3: START during RUN is ignored; 0x12 + 0x34 = 0x46
        run_op(8'h12, 8'h34, 8'hFE, 3, 8'hAA, 8'h55);
        chk("t3_finished",  finished,      1);
        chk("t3_sum",       sum_at_done,   8'h46);
        chk("t3_carry",     carry_at_done, 1'b0);
        chk("t3_pulses",    done_pulses,   1);
        chk("t3_busy_cyc",  busy_cycles,   9);
        repeat (2) @(posedge clk);
        #1;
        chk("t3_no_queue",  BUSY,          1'b0);

        // 4: asynchronous reset mid-RUN
        @(negedge clk);
        A = 8'h80; B = 8'h80; START = 1'b1;
        @(posedge clk);
        #1;
        START = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t4_busy_pre",  BUSY, 1'b1);
        chk("t4_sum_pre",   SUM,  8'h46);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_sum",   SUM,   8'h00);
        chk("t4_rst_carry", CARRY, 1'b0);
        chk("t4_rst_busy",  BUSY,  1'b0);
        chk("t4_rst_done",  DONE,  1'b0);
        dn = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (DONE) dn++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (DONE || BUSY) dn++;
        end
        chk("t4_no_done",   dn, 0);
        run_op(8'h01, 8'h02, 8'h00, -1, 8'h00, 8'h00);
        chk("t4_finished",  finished,      1);
        chk("t4_sum",       sum_at_done,   8'h03);
        chk("t4_carry",     carry_at_done, 1'b0);

        // 5: START held high gives an operation every 10 cycles
        @(negedge clk);
        A = 8'h10; B = 8'h20; START = 1'b1;
        np  = 0;
        bad = 0;
        d   = '{-1, -1, -1};
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (DONE) begin
                if (np < 3) d[np] = k;
                np++;
                if (SUM !== 8'h30 || CARRY !== 1'b0) bad++;
            end
        end
        @(negedge clk);
        START = 1'b0;
        chk("t5_pulses",  np,   3);
        chk("t5_first",   d[0], 8);
        chk("t5_second",  d[1], 18);
        chk("t5_third",   d[2], 28);
        chk("t5_results", bad,  0);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_idle",    BUSY, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        // 6: subtraction
        SUB = 1'b1;
        run_op(8'h10, 8'h01, 8'h30, -1, 8'h00, 8'h00);
        chk("t6a_sum",   sum_at_done,   8'h0F);
        chk("t6a_carry", carry_at_done, 1'b1);
        run_op(8'h01, 8'h02, 8'h0F, -1, 8'h00, 8'h00);
        chk("t6b_sum",   sum_at_done,   8'hFF);
        chk("t6b_carry", carry_at_done, 1'b0);
        SUB = 1'b0;
        run_op(8'h01, 8'h02, 8'hFF, -1, 8'h00, 8'h00);
        chk("t6c_sum",   sum_at_done,   8'h03);
        chk("t6c_carry", carry_at_done, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
